rgb_conv_scheduler: RTL and testbench
=====================================

# rgb_conv_scheduler

Sequences the colour-space conversion pass. Streams full-resolution (4:4:4) Y, U and V words from the external SRAM into the sibling RGB converter on its fixed 3-phase cadence. Packs the converted R/G/B bytes into 16-bit words and writes them back to the SRAM RGB region. Sits between the top-level SRAM port mux and the converter, and is started and monitored by the top-level FSM.

## Interface
Parameters:
- PIXEL_PAIRS, 38400: pixel pairs per frame (320x240/2); one Y/U/V word holds 2 pixels.
- Y_BASE, 18'd0: first Y word.
- U_BASE, 18'd38400: first U word.
- V_BASE, 18'd76800: first V word.
- RGB_BASE, 18'd146944: first RGB word.

Ports (one clock; reset is asynchronous and active-low):
- CLOCK_50_I  in  1  50 MHz clock.
- resetn  in  1  async active-low reset.
- start  in  1  level, sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the done cycle.
- done  out  1  one-cycle pulse after the last write.
- SRAM_address  out  18  word address.
- SRAM_write_data  out  16  write word.
- SRAM_we_n  out  1  active-low write enable.
- SRAM_read_data  in  16  valid 2 cycles after its address was driven.
- enable_RGB  out  1  advances the converter phase.
- Y_in_RGB, U_in_RGB, V_in_RGB  out  32 each  zero-extended 8-bit sample.
- R_buff, G_buff, B_buff  in  8 each  registered converter results.

## Operation
- States: IDLE, RUN, DONE. IDLE->RUN on start. RUN->DONE after iteration N+1 slot 5. DONE->IDLE unconditionally after 1 cycle.
- RUN consists of iterations i = 0..N+1 (N = PIXEL_PAIRS), 6 slots each (slot counter 0..5). Iteration i performs three tasks:
  - Reads pair i, if i<N.
  - Converts pair i-1, if 1<=i<=N.
  - Writes pair i-2, if i>=2.
- Read slots (i<N):
  - Slot 0 reads Y_BASE+i, slot 1 reads U_BASE+i, slot 2 reads V_BASE+i.
  - Data arrives in slots 2, 3 and 4 and is latched into staging registers at the end of that slot.
  - Staging is copied into the converter input registers at the end of slot 5.
- Converter inputs:
  - Slots 0-2 drive the even pixel (word[15:8]); slots 3-5 drive the odd pixel (word[7:0]).
  - Inputs stay stable across the 3 phases.
- enable_RGB is high in all 6 slots of conversion iterations and low otherwise.
  - The converter phase and `slot mod 3` therefore stay aligned; both reset to 0.
- Result capture:
  - End of slot 3: latch R0, G0 and B0 into even-hold registers.
  - End of slot 5: copy even-hold plus R1, G1 and B1 into the write registers.
- Write slots (i>=2): slots 3, 4 and 5 write {R0,G0}, {B0,R1} and {G1,B1}.
  - Target is RGB_BASE+3(i-2)+(slot-3).
  - SRAM_we_n is low only in these slots.
- Arithmetic rules:
  - Address counters are 18 bit and never wrap for legal parameters.
  - Results are not clipped; the bytes are used as delivered by the converter.
- start while busy is ignored. If start is still high in IDLE after done, a new pass begins.

## Timing
- Reset values: state IDLE, SRAM_address 0, SRAM_write_data 0, SRAM_we_n 1, enable_RGB 0, Y/U/V_in_RGB 0, busy 0, done 0. All counters and hold registers are 0.
- Start accepted at edge t: iteration 0 slot 0 occupies cycle t+1. RUN lasts exactly 6(N+2) cycles, and done is high in the following cycle.
- Full frame: 230412 RUN cycles.
- SRAM accesses: exactly 3N reads and 3N writes. There is never a read and a write in the same cycle, and no idle bus slot once in steady state.
- Reset mid-run: all outputs return to reset values asynchronously, with SRAM_we_n high immediately. There is no resume; a partial frame stays in SRAM.
- N=1 is legal: iteration 1 converts pair 0 and iteration 2 writes it.

## Structure
- Shared package holds:
  - the SRAM region base constants;
  - the frame size constant;
  - the state enum (IDLE/RUN/DONE);
  - the 3-bit slot type.
- The block has no sub-module. The converter is a sibling instance connected at top level and shares CLOCK_50_I and resetn.
- The scheduler contains its own slot FSM and address counters.

## Test plan
- Reset: hold resetn low, then release. All outputs equal their reset values; busy stays 0 with start low.
- N=1, Y=0x1010, U=V=0x8080: writes 0x0000 to RGB_BASE..+2; done at start+19.
- N=1, Y=0xEBEB, U=V=0x8080: writes 0xFEFE three times.
- N=4, ramp data: reads Y/U/V 0..3 in slots 0..2. There are 12 consecutive writes to RGB_BASE..+11; SRAM_we_n is low exactly 12 cycles, never in slots 0..2; enable_RGB is high exactly 24 cycles.
- N=4, resetn pulsed low at iteration 2 slot 4: SRAM_we_n goes high that same cycle and busy drops. On restart the full frame is rewritten correctly.
- start pulsed during RUN: no effect. start held high across done: the second pass begins the cycle after IDLE is re-entered.

Source files
------------

// File: rtl/rgb_conv_scheduler_pkg.sv
// Shared definitions for the colour-space conversion scheduler:
// SRAM region map, frame size, top-level state and slot types.
package rgb_conv_scheduler_pkg;

   localparam int          PIXEL_PAIRS_FRAME = 38400;      // 320x240 / 2
   localparam logic [17:0] Y_BASE_ADDR       = 18'd0;
   localparam logic [17:0] U_BASE_ADDR       = 18'd38400;
   localparam logic [17:0] V_BASE_ADDR       = 18'd76800;
   localparam logic [17:0] RGB_BASE_ADDR     = 18'd146944;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef logic [2:0] slot_t;

endpackage

// File: rtl/rgb_conv_scheduler.sv
// Colour-space conversion pass scheduler. Each 6-slot iteration reads one
// Y/U/V pixel pair, feeds the previous pair through the 3-phase converter
// (even pixel in slots 0-2, odd pixel in slots 3-5) and writes the pair
// before that back as three packed RGB words in slots 3-5.
module rgb_conv_scheduler
   import rgb_conv_scheduler_pkg::*;
#(
   parameter int          PIXEL_PAIRS = PIXEL_PAIRS_FRAME,
   parameter logic [17:0] Y_BASE      = Y_BASE_ADDR,
   parameter logic [17:0] U_BASE      = U_BASE_ADDR,
   parameter logic [17:0] V_BASE      = V_BASE_ADDR,
   parameter logic [17:0] RGB_BASE    = RGB_BASE_ADDR
) (
   input  logic        CLOCK_50_I,
   input  logic        resetn,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   input  logic [15:0] SRAM_read_data,
   output logic        enable_RGB,
   output logic [31:0] Y_in_RGB,
   output logic [31:0] U_in_RGB,
   output logic [31:0] V_in_RGB,
   input  logic [7:0]  R_buff,
   input  logic [7:0]  G_buff,
   input  logic [7:0]  B_buff
);

   localparam logic [17:0] NUM_PAIRS = 18'(PIXEL_PAIRS);
   localparam logic [17:0] LAST_ITER = 18'(PIXEL_PAIRS + 1);

   state_t      state_q, state_d;
   slot_t       slot_q, slot_d;
   logic [17:0] iter_q, iter_d;
   logic [17:0] wr_addr_q, wr_addr_d;

   logic [15:0] y_stg_q, u_stg_q, v_stg_q;
   logic [15:0] y_cnv_q, u_cnv_q, v_cnv_q;
   logic [23:0] even_q;      // {R0,G0,B0} of the pair being converted
   logic [47:0] wr_q;        // {R0,G0,B0,R1,G1,B1} of the pair being written

   logic run, rd_iter, cv_iter, wr_iter, wr_slot, wr_act, rd_act, odd_pix;

   assign run     = (state_q == RUN);
   assign rd_iter = (iter_q < NUM_PAIRS);
   assign cv_iter = (iter_q != 18'd0) && (iter_q <= NUM_PAIRS);
   assign wr_iter = (iter_q >= 18'd2);
   assign wr_slot = (slot_q >= 3'd3);
   assign wr_act  = run && wr_iter && wr_slot;
   assign rd_act  = run && rd_iter && !wr_slot;
   assign odd_pix = wr_slot;

   assign busy       = run;
   assign done       = (state_q == DONE);
   assign enable_RGB = run && cv_iter;

   // Converter inputs: the selected byte stays stable for the 3 converter phases.
   assign Y_in_RGB = {24'd0, odd_pix ? y_cnv_q[7:0] : y_cnv_q[15:8]};
   assign U_in_RGB = {24'd0, odd_pix ? u_cnv_q[7:0] : u_cnv_q[15:8]};
   assign V_in_RGB = {24'd0, odd_pix ? v_cnv_q[7:0] : v_cnv_q[15:8]};

   // State, slot, iteration and write-address registers.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         slot_q    <= 3'd0;
         iter_q    <= 18'd0;
         wr_addr_q <= 18'd0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         iter_q    <= iter_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   // Next-state logic: slot counts 0..5, iteration advances after slot 5.
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      iter_d    = iter_q;
      wr_addr_d = wr_addr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               slot_d    = 3'd0;
               iter_d    = 18'd0;
               wr_addr_d = RGB_BASE;
            end
         end
         RUN: begin
            if (wr_act) wr_addr_d = wr_addr_q + 18'd1;
            if (slot_q == 3'd5) begin
               slot_d = 3'd0;
               iter_d = iter_q + 18'd1;
               if (iter_q == LAST_ITER) state_d = DONE;
            end else begin
               slot_d = slot_q + 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // SRAM bus: reads in slots 0-2, packed RGB writes in slots 3-5.
   always_comb begin
      SRAM_address    = 18'd0;
      SRAM_write_data = 16'd0;
      SRAM_we_n       = 1'b1;
      if (wr_act) begin
         SRAM_address = wr_addr_q;
         SRAM_we_n    = 1'b0;
         case (slot_q)
            3'd3:    SRAM_write_data = wr_q[47:32];
            3'd4:    SRAM_write_data = wr_q[31:16];
            default: SRAM_write_data = wr_q[15:0];
         endcase
      end else if (rd_act) begin
         case (slot_q)
            3'd0:    SRAM_address = Y_BASE + iter_q;
            3'd1:    SRAM_address = U_BASE + iter_q;
            default: SRAM_address = V_BASE + iter_q;
         endcase
      end
   end

   // Read staging, converter input load and result capture.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         y_stg_q <= 16'd0;
         u_stg_q <= 16'd0;
         v_stg_q <= 16'd0;
         y_cnv_q <= 16'd0;
         u_cnv_q <= 16'd0;
         v_cnv_q <= 16'd0;
         even_q  <= 24'd0;
         wr_q    <= 48'd0;
      end else if (run) begin
         if (rd_iter) begin
            case (slot_q)
               3'd2: y_stg_q <= SRAM_read_data;
               3'd3: u_stg_q <= SRAM_read_data;
               3'd4: v_stg_q <= SRAM_read_data;
               3'd5: begin
                  y_cnv_q <= y_stg_q;
                  u_cnv_q <= u_stg_q;
                  v_cnv_q <= v_stg_q;
               end
               default: ;
            endcase
         end
         if (cv_iter) begin
            if (slot_q == 3'd3) even_q <= {R_buff, G_buff, B_buff};
            if (slot_q == 3'd5) wr_q   <= {even_q, R_buff, G_buff, B_buff};
         end
      end
   end

endmodule

// File: tb/tb_rgb_conv_scheduler.sv
// Bench for rgb_conv_scheduler: two instances (N=1 and N=4), each with a
// 2-cycle-latency SRAM model and a 3-phase RGB converter model.
module tb_rgb_conv_scheduler;

   localparam int U_B   = 38400;
   localparam int V_B   = 76800;
   localparam int RGB_B = 146944;

   logic        clk = 1'b0;
   logic [1:0]  start;
   logic [1:0]  rstn;
   logic [15:0] ymem [2][4];
   logic [15:0] umem [2][4];
   logic [15:0] vmem [2][4];
   logic [15:0] exp_w [12];
   logic [23:0] ev, od;
   logic [15:0] yw, uw, vw;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          dcyc, hits;

   always #10 clk = ~clk;

   function automatic logic [7:0] clip8(input int x);
      if (x < 0)   return 8'd0;
      if (x > 255) return 8'd255;
      return 8'(x);
   endfunction

   // BT.601 YUV->RGB, 16.16 fixed point, clipped to a byte.
   function automatic logic [23:0] conv(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
      int c, d, e, r, g, b;
      c = int'(y) - 16;
      d = int'(u) - 128;
      e = int'(v) - 128;
      r = (76284 * c + 104595 * e) >>> 16;
      g = (76284 * c - 25624 * d - 53281 * e) >>> 16;
      b = (76284 * c + 132251 * d) >>> 16;
      return {clip8(r), clip8(g), clip8(b)};
   endfunction

   function automatic int rd_base(input int s);
      if (s == 0) return 0;
      if (s == 1) return U_B;
      return V_B;
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g
      localparam int N = (k == 0) ? 1 : 4;
      logic        busy, done, we_n, en;
      logic [17:0] addr, a1, a2;
      logic [15:0] wdata, rdata;
      logic [31:0] yin, uin, vin;
      logic [7:0]  rb, gb, bb;
      logic [1:0]  ph;
      int          idx, wcnt, encnt, webad, rdbad, rdcnt, zbad;
      logic [17:0] wa [16];
      logic [15:0] wd [16];

      rgb_conv_scheduler #(.PIXEL_PAIRS(N)) dut (
         .CLOCK_50_I     (clk),
         .resetn         (rstn[k]),
         .start          (start[k]),
         .busy           (busy),
         .done           (done),
         .SRAM_address   (addr),
         .SRAM_write_data(wdata),
         .SRAM_we_n      (we_n),
         .SRAM_read_data (rdata),
         .enable_RGB     (en),
         .Y_in_RGB       (yin),
         .U_in_RGB       (uin),
         .V_in_RGB       (vin),
         .R_buff         (rb),
         .G_buff         (gb),
         .B_buff         (bb)
      );

      // SRAM read data appears two cycles after its address
      always @(posedge clk) begin
         a1 <= addr;
         a2 <= a1;
      end

      always_comb begin
         rdata = 16'hDEAD;
         if (a2 < 18'd4)                              rdata = ymem[k][a2[1:0]];
         else if (a2 >= 18'd38400 && a2 < 18'd38404)  rdata = umem[k][a2[1:0]];
         else if (a2 >= 18'd76800 && a2 < 18'd76804)  rdata = vmem[k][a2[1:0]];
      end

      // converter: result registered at the end of phase 1
      always @(posedge clk or negedge rstn[k]) begin
         if (!rstn[k]) begin
            ph <= 2'd0;
            rb <= 8'd0;
            gb <= 8'd0;
            bb <= 8'd0;
         end else if (en) begin
            ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
            if (ph == 2'd1) {rb, gb, bb} <= conv(yin[7:0], uin[7:0], vin[7:0]);
         end
      end

      // bus monitor, slot position counted from the first busy cycle
      always @(negedge clk) begin
         if (!busy && !done) begin
            idx   <= 0;
            wcnt  <= 0;
            encnt <= 0;
            webad <= 0;
            rdbad <= 0;
            rdcnt <= 0;
            zbad  <= 0;
         end else if (busy) begin
            idx <= idx + 1;
            if (en) encnt <= encnt + 1;
            if (yin[31:8] != 24'd0 || uin[31:8] != 24'd0 || vin[31:8] != 24'd0) zbad <= zbad + 1;
            if (!we_n) begin
               wcnt <= wcnt + 1;
               if (wcnt < 16) begin
                  wa[wcnt[3:0]] <= addr;
                  wd[wcnt[3:0]] <= wdata;
               end
               if (idx % 6 < 3) webad <= webad + 1;
            end
            if (idx % 6 < 3 && idx / 6 < N) begin
               rdcnt <= rdcnt + 1;
               if (int'(addr) != rd_base(idx % 6) + idx / 6) rdbad <= rdbad + 1;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic done_of(input int k);
      return (k == 0) ? g[0].done : g[1].done;
   endfunction

   // counts negedges after the accepting edge; the first is cycle 1
   task automatic wait_done(input int k, input bit drop, output int dc);
      dc = 0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (drop) start[k] = 1'b0;
         if (done_of(k)) begin
            dc = c;
            break;
         end
      end
   endtask

   task automatic run_pass(input int k, input bit drop, output int dc);
      @(negedge clk);
      start[k] = 1'b1;
      wait_done(k, drop, dc);
   endtask

   task automatic check_n1(input string tag, input logic [15:0] w);
      check_eq({tag, "_wcnt"}, 32'(g[0].wcnt), 32'd3);
      check_eq({tag, "_encnt"}, 32'(g[0].encnt), 32'd6);
      for (int j = 0; j < 3; j++) begin
         check_eq($sformatf("%s_wa%0d", tag, j), 32'(g[0].wa[j]), 32'(RGB_B + j));
         check_eq($sformatf("%s_wd%0d", tag, j), 32'(g[0].wd[j]), 32'(w));
      end
   endtask

   task automatic check_n4(input string tag);
      check_eq({tag, "_wcnt"}, 32'(g[1].wcnt), 32'd12);
      check_eq({tag, "_webad"}, 32'(g[1].webad), 32'd0);
      check_eq({tag, "_encnt"}, 32'(g[1].encnt), 32'd24);
      check_eq({tag, "_rdcnt"}, 32'(g[1].rdcnt), 32'd12);
      check_eq({tag, "_rdbad"}, 32'(g[1].rdbad), 32'd0);
      check_eq({tag, "_zext"}, 32'(g[1].zbad), 32'd0);
      for (int j = 0; j < 12; j++) begin
         check_eq($sformatf("%s_wa%0d", tag, j), 32'(g[1].wa[j]), 32'(RGB_B + j));
         check_eq($sformatf("%s_wd%0d", tag, j), 32'(g[1].wd[j]), 32'(exp_w[j]));
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      start = 2'b00;
      rstn  = 2'b00;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 4; i++) begin
            ymem[k][i] = 16'h0000;
            umem[k][i] = 16'h8080;
            vmem[k][i] = 16'h8080;
         end
      ymem[0][0] = 16'h1010;
      for (int i = 0; i < 4; i++) begin
         ymem[1][i] = {8'(48 + 40 * i), 8'(68 + 40 * i)};
         umem[1][i] = {8'(100 + 20 * i), 8'(150 - 20 * i)};
         vmem[1][i] = {8'(160 - 15 * i), 8'(90 + 25 * i)};
      end
      for (int p = 0; p < 4; p++) begin
         yw = ymem[1][p];
         uw = umem[1][p];
         vw = vmem[1][p];
         ev = conv(yw[15:8], uw[15:8], vw[15:8]);
         od = conv(yw[7:0], uw[7:0], vw[7:0]);
         exp_w[3 * p]     = {ev[23:16], ev[15:8]};
         exp_w[3 * p + 1] = {ev[7:0], od[23:16]};
         exp_w[3 * p + 2] = {od[15:8], od[7:0]};
      end

      // reset state
      repeat (3) @(negedge clk);
      check_eq("rst_addr", 32'(g[0].addr), 32'd0);
      check_eq("rst_wdata", 32'(g[0].wdata), 32'd0);
      check_eq("rst_we_n", 32'(g[0].we_n), 32'd1);
      check_eq("rst_en", 32'(g[0].en), 32'd0);
      check_eq("rst_yin", g[0].yin, 32'd0);
      check_eq("rst_uin", g[0].uin, 32'd0);
      check_eq("rst_vin", g[0].vin, 32'd0);
      check_eq("rst_busy", 32'(g[0].busy), 32'd0);
      check_eq("rst_done", 32'(g[0].done), 32'd0);
      check_eq("rst_we_n_4", 32'(g[1].we_n), 32'd1);
      rstn = 2'b11;
      hits = 0;
      repeat (5) begin
         @(negedge clk);
         if (g[0].busy || g[1].busy) hits++;
      end
      check_eq("idle_busy", 32'(hits), 32'd0);

      // N=1 black
      run_pass(0, 1'b1, dcyc);
      check_eq("A_done_cyc", 32'(dcyc), 32'd19);
      check_n1("A", 16'h0000);

      // N=1 white
      ymem[0][0] = 16'hEBEB;
      run_pass(0, 1'b1, dcyc);
      check_eq("B_done_cyc", 32'(dcyc), 32'd19);
      check_n1("B", 16'hFEFE);

      // N=4 ramp
      run_pass(1, 1'b1, dcyc);
      check_eq("C_done_cyc", 32'(dcyc), 32'd37);
      check_n4("C");

      // N=4 reset at iteration 2 slot 4, then full restart
      @(negedge clk);
      start[1] = 1'b1;
      @(negedge clk);
      start[1] = 1'b0;
      repeat (16) @(negedge clk);
      check_eq("D_we_pre", 32'(g[1].we_n), 32'd0);
      #2 rstn[1] = 1'b0;
      #1;
      check_eq("D_we_rst", 32'(g[1].we_n), 32'd1);
      check_eq("D_busy_rst", 32'(g[1].busy), 32'd0);
      check_eq("D_addr_rst", 32'(g[1].addr), 32'd0);
      check_eq("D_en_rst", 32'(g[1].en), 32'd0);
      check_eq("D_yin_rst", g[1].yin, 32'd0);
      @(negedge clk);
      rstn[1] = 1'b1;
      repeat (2) @(negedge clk);
      run_pass(1, 1'b1, dcyc);
      check_eq("D_done_cyc", 32'(dcyc), 32'd37);
      check_n4("D");

      // start pulsed during RUN is ignored
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (4) @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0, 1'b1, dcyc);
      check_eq("E_done_cyc", 32'(dcyc), 32'd13);
      hits = 0;
      repeat (4) begin
         @(negedge clk);
         if (g[0].busy) hits++;
      end
      check_eq("E_no_restart", 32'(hits), 32'd0);

      // start held across done: back-to-back pass
      run_pass(0, 1'b0, dcyc);
      check_eq("F_done_cyc", 32'(dcyc), 32'd19);
      @(negedge clk);
      check_eq("F_idle_busy", 32'(g[0].busy), 32'd0);
      @(negedge clk);
      check_eq("F_rerun_busy", 32'(g[0].busy), 32'd1);
      start[0] = 1'b0;
      wait_done(0, 1'b1, dcyc);
      check_eq("F_done2_cyc", 32'(dcyc), 32'd18);
      check_n1("F", 16'hFEFE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
